updown_counter: RTL and testbench

UPDOWN_COUNTER -- requirements
Module: updown_counter

---
 rtl/updown_counter.sv | 108 ++++++++++
 tb/tb_updown_counter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// ----------------------------------------------------------------------------
// updown_counter
//
// Purpose:
//    Up/down counter with a run-time inclusive upper limit and a wrap or
//    saturate boundary behaviour. Boundary events set sticky overflow /
//    underflow flags and give a one-cycle registered wrap pulse. Synchronous
//    load and synchronous active-high reset.
//
// Parameters:
//    WORD         counter and data width in bits (2..32)
//    RESET_VALUE  count loaded on reset
//
// Ports:
//    clock_in        in   1     sole clock, rising edge
//    reset_in        in   1     synchronous active-high reset
//    enable_in       in   1     count enable
//    direction_in    in   1     1 = up, 0 = down
//    saturate_in     in   1     0 = wrap mode, 1 = saturate mode
//    limit_in        in   WORD  inclusive upper bound of the count range
//    load_in         in   1     synchronous load strobe
//    load_value_in   in   WORD  value written to the count on load
//    clear_flags_in  in   1     clears the sticky flags
//    count_out       out  WORD  registered count
//    overflow_out    out  1     sticky up-boundary flag
//    underflow_out   out  1     sticky down-boundary flag
//    wrap_out        out  1     one-cycle pulse after each boundary event
//    at_limit_out    out  1     combinational, count == limit_in
//    at_zero_out     out  1     combinational, count == 0
// ----------------------------------------------------------------------------
module updown_counter #(
   parameter int unsigned     WORD        = 8,
   parameter logic [WORD-1:0] RESET_VALUE = '0
) (
   input  logic            clock_in,
   input  logic            reset_in,
   input  logic            enable_in,
   input  logic            direction_in,
   input  logic            saturate_in,
   input  logic [WORD-1:0] limit_in,
   input  logic            load_in,
   input  logic [WORD-1:0] load_value_in,
   input  logic            clear_flags_in,
   output logic [WORD-1:0] count_out,
   output logic            overflow_out,
   output logic            underflow_out,
   output logic            wrap_out,
   output logic            at_limit_out,
   output logic            at_zero_out
);

   localparam logic [WORD-1:0] ONE = WORD'(1);

   logic [WORD-1:0] count_next;
   logic            up_event;
   logic            down_event;

   // Next-count and boundary-event decode. Load outranks counting, so no
   // boundary event can be reported on a load cycle. An up-count at or
   // above the limit is a boundary event even when the count was loaded
   // above the limit, which makes a lowered limit take effect immediately.
   // A down-count only hits the boundary at zero, so a count above the limit
   // simply steps down.
   always_comb begin
      count_next = count_out;
      up_event   = 1'b0;
      down_event = 1'b0;
      if (load_in) begin
         count_next = load_value_in;
      end else if (enable_in) begin
         if (direction_in) begin
            if (count_out >= limit_in) begin
               up_event   = 1'b1;
               count_next = saturate_in ? limit_in : '0;
            end else begin
               count_next = count_out + ONE;
            end
         end else begin
            if (count_out == '0) begin
               down_event = 1'b1;
               count_next = saturate_in ? '0 : limit_in;
            end else begin
               count_next = count_out - ONE;
            end
         end
      end
   end

   // State register. A boundary event in the same cycle as a flag clear
   // leaves its flag set; the clear acts regardless of enable and load.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         count_out     <= RESET_VALUE;
         overflow_out  <= 1'b0;
         underflow_out <= 1'b0;
         wrap_out      <= 1'b0;
      end else begin
         count_out     <= count_next;
         overflow_out  <= up_event | (overflow_out & ~clear_flags_in);
         underflow_out <= down_event | (underflow_out & ~clear_flags_in);
         wrap_out      <= up_event | down_event;
      end
   end

   assign at_limit_out = (count_out == limit_in);
   assign at_zero_out  = (count_out == '0);

endmodule

// File: tb/tb_updown_counter.sv
// ----------------------------------------------------------------------------
// tb_updown_counter
//
// Purpose:
//    Table-driven bench for updown_counter (WORD = 8, RESET_VALUE = 0).
//    Each record holds the inputs for one clock edge and the hand-computed
//    outputs expected just after that edge.
// ----------------------------------------------------------------------------
module tb_updown_counter;

   localparam int WORD = 8;

   typedef struct {
      logic            rst;
      logic            ld;
      logic [WORD-1:0] ld_val;
      logic            en;
      logic            dir;
      logic            sat;
      logic [WORD-1:0] lim;
      logic            clr;
      logic [WORD-1:0] exp_count;
      logic            exp_ovf;
      logic            exp_unf;
      logic            exp_wrap;
   } vec_t;

   logic            clock_in = 1'b0;
   logic            reset_in = 1'b1;
   logic            enable_in = 1'b0;
   logic            direction_in = 1'b1;
   logic            saturate_in = 1'b0;
   logic [WORD-1:0] limit_in = '0;
   logic            load_in = 1'b0;
   logic [WORD-1:0] load_value_in = '0;
   logic            clear_flags_in = 1'b0;
   logic [WORD-1:0] count_out;
   logic            overflow_out;
   logic            underflow_out;
   logic            wrap_out;
   logic            at_limit_out;
   logic            at_zero_out;

   int errors = 0;
   int checks = 0;
   vec_t vecs[$];

   updown_counter #(.WORD(WORD), .RESET_VALUE(8'h00)) dut (
      .clock_in       (clock_in),
      .reset_in       (reset_in),
      .enable_in      (enable_in),
      .direction_in   (direction_in),
      .saturate_in    (saturate_in),
      .limit_in       (limit_in),
      .load_in        (load_in),
      .load_value_in  (load_value_in),
      .clear_flags_in (clear_flags_in),
      .count_out      (count_out),
      .overflow_out   (overflow_out),
      .underflow_out  (underflow_out),
      .wrap_out       (wrap_out),
      .at_limit_out   (at_limit_out),
      .at_zero_out    (at_zero_out)
   );

   always #5 clock_in = ~clock_in;

   task automatic addVec(input logic rst, input logic ld, input logic [WORD-1:0] ld_val,
                         input logic en, input logic dir, input logic sat,
                         input logic [WORD-1:0] lim, input logic clr,
                         input logic [WORD-1:0] ec, input logic eo,
                         input logic eu, input logic ew);
      vec_t v;
      v.rst = rst; v.ld = ld; v.ld_val = ld_val; v.en = en; v.dir = dir;
      v.sat = sat; v.lim = lim; v.clr = clr; v.exp_count = ec;
      v.exp_ovf = eo; v.exp_unf = eu; v.exp_wrap = ew;
      vecs.push_back(v);
   endtask

   task automatic checkOutput(input string name, input int idx,
                              input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s vec %0d: got %0h expected %0h", name, idx, actual, expected);
      end
   endtask

   // Drive one record away from the active edge, let the edge happen, then
   // compare one time unit later while the same inputs are still applied.
   task automatic applyStimulus(input vec_t v, input int idx);
      @(negedge clock_in);
      reset_in       = v.rst;
      load_in        = v.ld;
      load_value_in  = v.ld_val;
      enable_in      = v.en;
      direction_in   = v.dir;
      saturate_in    = v.sat;
      limit_in       = v.lim;
      clear_flags_in = v.clr;
      @(posedge clock_in);
      #1;
      checkOutput("count",     idx, 32'(count_out),     32'(v.exp_count));
      checkOutput("overflow",  idx, 32'(overflow_out),  32'(v.exp_ovf));
      checkOutput("underflow", idx, 32'(underflow_out), 32'(v.exp_unf));
      checkOutput("wrap",      idx, 32'(wrap_out),      32'(v.exp_wrap));
      checkOutput("at_limit",  idx, 32'(at_limit_out),  32'(v.exp_count == v.lim));
      checkOutput("at_zero",   idx, 32'(at_zero_out),   32'(v.exp_count == '0));
   endtask

   initial begin
      // rst ld val en dir sat lim clr | count ovf unf wrap
      addVec(1, 0, 0, 0, 1, 0, 9, 0,   0, 0, 0, 0);

      // Wrap up through limit 9 for 12 edges
      for (int i = 1; i <= 12; i++)
         addVec(0, 0, 0, 1, 1, 0, 9, 0, 8'(i % 10), i >= 10, 0, i == 10);

      // Clear alone with enable low holds the count
      addVec(0, 0, 0, 0, 1, 0, 9, 1,   2, 0, 0, 0);

      // Saturate down from a loaded 2: 1, 0, 0, 0 then hold
      addVec(0, 1, 2, 0, 0, 1, 9, 0,   2, 0, 0, 0);
      addVec(0, 0, 0, 1, 0, 1, 9, 0,   1, 0, 0, 0);
      addVec(0, 0, 0, 1, 0, 1, 9, 0,   0, 0, 0, 0);
      addVec(0, 0, 0, 1, 0, 1, 9, 0,   0, 0, 1, 1);
      addVec(0, 0, 0, 1, 0, 1, 9, 0,   0, 0, 1, 1);
      addVec(0, 0, 0, 0, 0, 1, 9, 0,   0, 0, 1, 0);
      addVec(0, 0, 0, 0, 0, 0, 9, 1,   0, 0, 0, 0);

      // Event wins over a simultaneous clear; clear alone then drops the flag
      addVec(0, 1, 9, 0, 1, 0, 9, 0,   9, 0, 0, 0);
      addVec(0, 0, 0, 1, 1, 0, 9, 0,   0, 1, 0, 1);
      addVec(0, 1, 9, 0, 1, 0, 9, 0,   9, 1, 0, 0);
      addVec(0, 0, 0, 1, 1, 0, 9, 1,   0, 1, 0, 1);
      addVec(0, 0, 0, 0, 1, 0, 9, 1,   0, 0, 0, 0);

      // Load above the limit, then limit lowered below the count
      addVec(0, 1, 200, 0, 1, 0, 9, 0,   200, 0, 0, 0);
      addVec(0, 0, 0, 1, 1, 0, 50, 0,    0, 1, 0, 1);
      addVec(0, 1, 200, 0, 1, 0, 50, 0,  200, 1, 0, 0);
      addVec(0, 0, 0, 0, 1, 0, 50, 1,    200, 0, 0, 0);
      addVec(0, 0, 0, 1, 0, 0, 50, 0,    199, 0, 0, 0);

      // Saturate up clamps to the limit, repeatedly
      addVec(0, 0, 0, 1, 1, 1, 50, 0,    50, 1, 0, 1);
      addVec(0, 0, 0, 1, 1, 1, 50, 0,    50, 1, 0, 1);
      addVec(0, 0, 0, 0, 1, 1, 50, 0,    50, 1, 0, 0);

      // Wrap down from zero lands on the limit
      addVec(0, 1, 0, 0, 0, 0, 9, 0,     0, 1, 0, 0);
      addVec(0, 0, 0, 1, 0, 0, 9, 0,     9, 1, 1, 1);

      // Limit of zero: every count is a boundary event with result 0
      addVec(0, 1, 0, 0, 1, 0, 0, 1,     0, 0, 0, 0);
      addVec(0, 0, 0, 1, 1, 0, 0, 0,     0, 1, 0, 1);
      addVec(0, 0, 0, 1, 0, 0, 0, 0,     0, 1, 1, 1);
      addVec(0, 0, 0, 1, 0, 1, 0, 0,     0, 1, 1, 1);

      // Reset outranks load and enable; load applies on the next edge
      addVec(1, 1, 8'h55, 1, 1, 0, 255, 0,  0, 0, 0, 0);
      addVec(0, 1, 8'h55, 1, 1, 0, 255, 0,  8'h55, 0, 0, 0);

      // Reset mid-count, resume on the first edge after release
      addVec(0, 0, 0, 1, 1, 0, 255, 0,  8'h56, 0, 0, 0);
      addVec(1, 0, 0, 1, 1, 0, 255, 0,  0, 0, 0, 0);
      addVec(0, 0, 0, 1, 1, 0, 255, 0,  1, 0, 0, 0);

      // Would-be event under reset leaves no wrap pulse; reset kills a pulse
      addVec(1, 0, 0, 1, 1, 0, 1, 0,    0, 0, 0, 0);
      addVec(0, 0, 0, 1, 1, 0, 1, 0,    1, 0, 0, 0);
      addVec(0, 0, 0, 1, 1, 0, 1, 0,    0, 1, 0, 1);
      addVec(1, 0, 0, 0, 1, 0, 1, 0,    0, 0, 0, 0);

      // Full-range wrap at the top of the word
      addVec(0, 1, 255, 0, 1, 0, 255, 0, 255, 0, 0, 0);
      addVec(0, 0, 0, 1, 1, 0, 255, 0,   0, 1, 0, 1);
      addVec(0, 0, 0, 1, 0, 0, 255, 1,   255, 0, 1, 1);

      for (int i = 0; i < vecs.size(); i++)
         applyStimulus(vecs[i], i);

      // Hand-written sequence: consecutive events give back-to-back pulses
      // and the pulse ends on the first non-event edge.
      @(negedge clock_in);
      reset_in = 1'b0; load_in = 1'b0; enable_in = 1'b1; direction_in = 1'b1;
      saturate_in = 1'b1; limit_in = 8'd3; clear_flags_in = 1'b0;
      // count is 255 >= 3: saturate clamps to 3 with an event
      for (int k = 0; k < 3; k++) begin
         @(posedge clock_in);
         #1;
         checkOutput("seq_count", 100 + k, 32'(count_out), 32'd3);
         checkOutput("seq_wrap",  100 + k, 32'(wrap_out),  32'd1);
      end
      @(negedge clock_in);
      direction_in = 1'b0;
      @(posedge clock_in);
      #1;
      checkOutput("seq_count", 103, 32'(count_out), 32'd2);
      checkOutput("seq_wrap",  103, 32'(wrap_out),  32'd0);
      checkOutput("seq_ovf",   103, 32'(overflow_out), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
